block_ram_clr: RTL and testbench
================================

Name: block_ram_clr

Overview:
Parametrised successor to the single-port frame RAM: a simple dual-port (1W/1R) synchronous block RAM with a hardware clear sequencer, read-enable with a valid strobe, and a selectable read-during-write mode. It also has an optional output pipeline register and address range checking. It sits between the pixel capture path (write side) and the Sobel window fetch (read side), and lets a frame buffer be zeroed between frames without the producer having to do it.

Parameters:
DATA_SIZE, 8, bits per data word
ADDR_SIZE, 14, address width
DATA_ELMT, 16384, number of stored words; must be <= 2**ADDR_SIZE
RDW_MODE, 0, same-address read during write: 0 = return old data, 1 = return new write_data
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear_req  input  1  single-cycle request to zero the whole memory
clear_busy  output  1  high while the clear sequencer runs
ready  output  1  high when in RUN; user accesses are honoured only when ready=1
write_en  input  1  write strobe
write_addr  input  ADDR_SIZE  write address
write_data  input  DATA_SIZE  write data
read_en  input  1  read strobe
read_addr  input  ADDR_SIZE  read address
data_out  output  DATA_SIZE  read data, held until the next valid read
data_valid  output  1  one-cycle pulse when data_out carries new read data
addr_err  output  1  one-cycle pulse: an honoured access had an address >= DATA_ELMT

Behaviour:
- Clock and reset: one clock (clk); rst_n asynchronous, active-low.
- Reset values, asserted immediately: state=CLEAR, clear counter=0, clear_busy=1, ready=0, data_out=0, data_valid=0, addr_err=0, pipeline registers=0.
- The memory array has no reset. Only the sequencer zeroes it.
- FSM states: CLEAR and RUN.
- CLEAR:
  - Each clock edge writes 0 to the address held in the counter, then increments the counter.
  - The first edge after rst_n rises writes address 0.
  - The edge that writes address DATA_ELMT-1 moves the FSM to RUN. On that same edge: clear_busy goes to 0, ready goes to 1, counter goes to 0.
  - A full clear takes exactly DATA_ELMT cycles.
  - clear_req, write_en and read_en are ignored. data_valid and addr_err stay 0.
- RUN:
  - If clear_req=1 on an edge: go to CLEAR with counter=0. clear_busy=1 and ready=0 from the next cycle.
  - Any user write or read in that same cycle is still honoured.
- Write (RUN, write_en=1):
  - write_addr < DATA_ELMT: mem[write_addr] <= write_data on the edge.
  - Otherwise: no write; addr_err=1 for one cycle.
- Read (RUN, read_en=1):
  - The address is sampled on the edge.
  - OUT_REG=0: data_out and data_valid=1 are updated on the same edge. Data is visible in the cycle after read_en.
  - OUT_REG=1: one more register stage, so data is visible two cycles after read_en.
  - Back-to-back reads: one result per cycle, fully pipelined.
  - read_addr >= DATA_ELMT: data_out=0 with data_valid=1, and addr_err=1.
  - read_en=0: data_valid=0 and data_out holds its value.
- Read during write, same in-range address on the same edge:
  - RDW_MODE=0: data returned is the old memory content.
  - RDW_MODE=1: data returned is write_data.
  - Different addresses do not interact.
- addr_err is the OR of the write error and the read error on a given edge.
- Reset mid-operation: everything returns to the reset values at once. In-flight read pipeline stages are discarded, with no data_valid. The clear restarts from address 0.
- clear_req while already in CLEAR is ignored; the clear is not restarted.
- The data_valid pipeline slot for a read accepted on the edge where RUN goes to CLEAR still completes, including under OUT_REG=1.

Test Plan:
All scenarios use DATA_SIZE=8, ADDR_SIZE=5, DATA_ELMT=20 unless stated.
- Reset release, then poll: ready rises after exactly 20 edges, clear_busy falls on the same edge. Reading addresses 0..19 afterwards returns 0x00 with data_valid pulses.
- Write 0xA5 to address 3, then read address 3 next cycle (OUT_REG=0) -> data_out=0xA5 and data_valid=1 one cycle after read_en. Repeat with OUT_REG=1 -> result two cycles after read_en.
- Write 0x11 to address 7. Then on one edge write 0x22 to address 7 and read address 7. RDW_MODE=0 -> 0x11; RDW_MODE=1 -> 0x22. A following read -> 0x22 in both modes.
- Write to address 25 -> addr_err pulses, and no stored word changes (scan 0..19). Read address 31 -> data_out=0x00, data_valid=1, addr_err=1.
- Fill addresses 0..19 with 0xFF, pulse clear_req -> clear_busy is high for 20 cycles. A write issued during that window is dropped. After clear, all locations read 0x00.
- Assert rst_n low for one cycle 10 cycles into a clear, with a read in flight under OUT_REG=1 -> no data_valid pulse, and the clear restarts: ready rises 20 edges after release.

Source files
------------

// File: rtl/block_ram_clr.sv
// Simple dual-port (1W/1R) block RAM with a hardware clear sequencer, read valid
// strobe, selectable read-during-write behaviour and optional output register.
module block_ram_clr #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 14,
  parameter int DATA_ELMT = 16384,
  parameter int RDW_MODE  = 0,
  parameter int OUT_REG   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 ready,
  input  logic                 write_en,
  input  logic [ADDR_SIZE-1:0] write_addr,
  input  logic [DATA_SIZE-1:0] write_data,
  input  logic                 read_en,
  input  logic [ADDR_SIZE-1:0] read_addr,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 addr_err
);

  // Handshake: there is no back-pressure. A write or read is accepted on any
  // edge where its strobe is high and ready=1; otherwise it is silently dropped.

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DATA_ELMT - 1);
  localparam logic [ADDR_SIZE:0]   ELMT_EXT  = (ADDR_SIZE + 1)'(DATA_ELMT);

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;

  logic [DATA_SIZE-1:0] mem [DATA_ELMT];

  logic                 wr_ok, rd_ok, wr_in, rd_in;
  logic [DATA_SIZE-1:0] rd_word;
  logic [DATA_SIZE-1:0] s1_data;
  logic                 s1_valid;
  logic                 err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_SIZE'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign ready      = (state_q == ST_RUN);

  assign wr_ok = ready && write_en;
  assign rd_ok = ready && read_en;
  assign wr_in = ({1'b0, write_addr} < ELMT_EXT);
  assign rd_in = ({1'b0, read_addr} < ELMT_EXT);

  // Array has no reset; the sequencer owns the write port while clearing.
  always_ff @(posedge clk) begin
    if (clear_busy) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok && wr_in) begin
      mem[write_addr] <= write_data;
    end
  end

  // Old data falls out of non-blocking semantics; new data needs an explicit bypass.
  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      rd_word = mem[read_addr];
      if ((RDW_MODE != 0) && wr_ok && (write_addr == read_addr)) begin
        rd_word = write_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_valid <= rd_ok;
      if (rd_ok) begin
        s1_data <= rd_word;
      end
      err_q <= (wr_ok && !wr_in) || (rd_ok && !rd_in);
    end
  end

  assign addr_err = err_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_SIZE-1:0] s2_data;
      logic                 s2_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign data_out   = s2_data;
      assign data_valid = s2_valid;
    end else begin : g_no_out_reg
      assign data_out   = s1_data;
      assign data_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_block_ram_clr.sv
// Directed bench for block_ram_clr: one instance with old-data RDW and latency 1,
// one with new-data RDW and latency 2, both driven by the same stimulus.
module tb_block_ram_clr;

  localparam int DS = 8;
  localparam int AS = 5;
  localparam int DE = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear_req = 1'b0;
  logic          write_en = 1'b0;
  logic [AS-1:0] write_addr = '0;
  logic [DS-1:0] write_data = '0;
  logic          read_en = 1'b0;
  logic [AS-1:0] read_addr = '0;

  logic          busy0, rdy0, dv0, err0;
  logic [DS-1:0] dout0;
  logic          busy1, rdy1, dv1, err1;
  logic [DS-1:0] dout1;

  int n_checks = 0;
  int n_err    = 0;

  logic [DS:0]   exp_q[$];
  logic [DS-1:0] h0 = '0;
  logic [DS-1:0] h1 = '0;

  typedef struct {
    logic          we;
    logic [AS-1:0] wa;
    logic [DS-1:0] wd;
    logic          re;
    logic [AS-1:0] ra;
    logic          ev;
    logic [DS-1:0] ed0;
    logic [DS-1:0] ed1;
    logic          ee;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  block_ram_clr #(
    .DATA_SIZE(DS), .ADDR_SIZE(AS), .DATA_ELMT(DE), .RDW_MODE(0), .OUT_REG(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(busy0), .ready(rdy0),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .data_out(dout0), .data_valid(dv0),
    .addr_err(err0)
  );

  block_ram_clr #(
    .DATA_SIZE(DS), .ADDR_SIZE(AS), .DATA_ELMT(DE), .RDW_MODE(1), .OUT_REG(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(busy1), .ready(rdy1),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .data_out(dout1), .data_valid(dv1),
    .addr_err(err1)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [DS-1:0] act, input logic [DS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; instance 0 is checked on this edge, instance 1 one edge later.
  task automatic cycle(input logic cr, input logic we, input logic [AS-1:0] wa,
                       input logic [DS-1:0] wd, input logic re, input logic [AS-1:0] ra,
                       input logic ev, input logic [DS-1:0] ed0, input logic [DS-1:0] ed1,
                       input logic ee, input logic eb);
    logic [DS:0] p;
    clear_req  = cr;
    write_en   = we;
    write_addr = wa;
    write_data = wd;
    read_en    = re;
    read_addr  = ra;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    write_en  = 1'b0;
    read_en   = 1'b0;
    if (ev) h0 = ed0;
    chk1("busy0", busy0, eb);
    chk1("ready0", rdy0, !eb);
    chk1("busy1", busy1, eb);
    chk1("ready1", rdy1, !eb);
    chk1("valid0", dv0, ev);
    chk8("dout0", dout0, h0);
    chk1("err0", err0, ee);
    chk1("err1", err1, ee);
    exp_q.push_back({ev, ed1});
    p = exp_q.pop_front();
    if (p[DS]) h1 = p[DS-1:0];
    chk1("valid1", dv1, p[DS]);
    chk8("dout1", dout1, h1);
  endtask

  task automatic idle(input logic eb);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, eb);
  endtask

  // Async reset for one edge, immediate reset-value checks, then a full clear count.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk1("rst_busy0", busy0, 1'b1);
    chk1("rst_ready0", rdy0, 1'b0);
    chk1("rst_valid0", dv0, 1'b0);
    chk1("rst_err0", err0, 1'b0);
    chk8("rst_dout0", dout0, '0);
    chk1("rst_busy1", busy1, 1'b1);
    chk1("rst_ready1", rdy1, 1'b0);
    chk1("rst_valid1", dv1, 1'b0);
    chk1("rst_err1", err1, 1'b0);
    chk8("rst_dout1", dout1, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    h0 = '0;
    h1 = '0;
    exp_q = {};
    exp_q.push_back('0);
    for (int i = 1; i <= DE; i++) begin
      // A clear_req mid-clear must not restart the count.
      cycle((i == 5), 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, (i < DE));
    end
  endtask

  function automatic logic [DS-1:0] tbl_mem(input int a);
    case (a)
      0:       return 8'hC3;
      3:       return 8'h99;
      7:       return 8'h22;
      19:      return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  task automatic scan(input logic after_tbl);
    logic [DS-1:0] e;
    for (int a = 0; a < DE; a++) begin
      e = after_tbl ? tbl_mem(a) : 8'h00;
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AS'(a), 1'b1, e, e, 1'b0, 1'b0);
    end
    idle(1'b0);
  endtask

  initial begin
    //            we    wa     wd     re    ra     ev    ed0    ed1    ee
    vecs[0]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd0,  1'b1, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd19, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 5'd3,  8'hA5, 1'b0, 5'd0,  1'b0, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd3,  1'b1, 8'hA5, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 5'd7,  8'h11, 1'b0, 5'd0,  1'b0, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 5'd7,  8'h22, 1'b1, 5'd7,  1'b1, 8'h11, 8'h22, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd7,  1'b1, 8'h22, 8'h22, 1'b0};
    vecs[7]  = '{1'b1, 5'd25, 8'h5A, 1'b0, 5'd0,  1'b0, 8'h00, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd31, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  1'b0, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 5'd19, 8'h3C, 1'b1, 5'd3,  1'b1, 8'hA5, 8'hA5, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd19, 1'b1, 8'h3C, 8'h3C, 1'b0};
    vecs[12] = '{1'b1, 5'd0,  8'hC3, 1'b1, 5'd25, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[13] = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd0,  1'b1, 8'hC3, 8'hC3, 1'b0};
    vecs[14] = '{1'b1, 5'd30, 8'h77, 1'b1, 5'd30, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[15] = '{1'b1, 5'd3,  8'h99, 1'b1, 5'd7,  1'b1, 8'h22, 8'h22, 1'b0};
    vecs[16] = '{1'b1, 5'd20, 8'hEE, 1'b1, 5'd19, 1'b1, 8'h3C, 8'h3C, 1'b1};
    vecs[17] = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd20, 1'b1, 8'h00, 8'h00, 1'b1};

    @(posedge clk);
    #1;
    reset_pulse();

    scan(1'b0);

    foreach (vecs[i]) begin
      cycle(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra,
            vecs[i].ev, vecs[i].ed0, vecs[i].ed1, vecs[i].ee, 1'b0);
    end
    idle(1'b0);
    scan(1'b1);

    // Fill with 0xFF, then clear with a read accepted on the RUN->CLEAR edge.
    for (int a = 0; a < DE; a++) begin
      cycle(1'b0, 1'b1, AS'(a), 8'hFF, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    end
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd5, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    for (int i = 1; i <= DE; i++) begin
      if (i == 10)
        cycle(1'b0, 1'b1, 5'd2, 8'h77, 1'b1, 5'd2, 1'b0, '0, '0, 1'b0, 1'b1);
      else
        cycle((i == 3), 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, (i < DE));
    end
    scan(1'b0);

    // Reset with a read still inside the two-stage pipeline.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd2, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    reset_pulse();

    // Reset ten cycles into a clear; the clear must restart from zero.
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) idle(1'b1);
    reset_pulse();

    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
